// File: rtl/vmujs_pkg.sv
// Shared encodings for the vmujs object builder: entry kinds, engine ops, FSM states.
package vmujs_pkg;

  typedef enum logic [2:0] {
    K_STR       = 3'd0,
    K_INT       = 3'd1,
    K_BOOL      = 3'd2,
    K_NULL      = 3'd3,
    K_UNDEF     = 3'd4,
    K_OBJ_BEGIN = 3'd5,
    K_OBJ_END   = 3'd6,
    K_RSVD      = 3'd7
  } kind_e;

  typedef enum logic [2:0] {
    OP_NEWOBJ     = 3'd0,
    OP_PUSH_STR   = 3'd1,
    OP_PUSH_INT   = 3'd2,
    OP_PUSH_BOOL  = 3'd3,
    OP_PUSH_NULL  = 3'd4,
    OP_PUSH_UNDEF = 3'd5,
    OP_SETPROP    = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ROOT, ST_READY, ST_PUSH, ST_SET, ST_CLOSE, ST_DONE
  } state_e;

  // Anything that cannot be pushed as a real value degrades to UNDEF.
  function automatic op_e push_op(input kind_e k);
    case (k)
      K_STR:   return OP_PUSH_STR;
      K_INT:   return OP_PUSH_INT;
      K_BOOL:  return OP_PUSH_BOOL;
      K_NULL:  return OP_PUSH_NULL;
      default: return OP_PUSH_UNDEF;
    endcase
  endfunction

endpackage

// File: rtl/vmujs_key_stack.sv
// LIFO of property keys for the currently open nested objects.
module vmujs_key_stack #(
  parameter int KEY_W     = 16,
  parameter int MAX_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_push,
  input  logic                               i_pop,
  input  logic [KEY_W-1:0]                   i_key,
  output logic [KEY_W-1:0]                   o_top,
  output logic                               o_empty,
  output logic                               o_full,
  output logic [$clog2(MAX_DEPTH+1)-1:0]     o_count
);
  localparam int CNT_W = $clog2(MAX_DEPTH + 1);
  localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [KEY_W-1:0] r_mem [MAX_DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_top_ptr;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_top_ptr = r_count - CNT_W'(1);
  assign w_wr_idx  = r_count[IDX_W-1:0];
  assign w_rd_idx  = w_top_ptr[IDX_W-1:0];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(MAX_DEPTH));
  assign o_top     = r_mem[w_rd_idx];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[w_wr_idx] <= i_key;
  end

endmodule

// File: rtl/vmujs_object_builder.sv
// Turns a typed key/value entry stream into NEWOBJ / PUSH_* / SETPROP engine commands,
// one top-level object per stream, with nesting tracked on a key stack.
module vmujs_object_builder
  import vmujs_pkg::*;
#(
  parameter int KEY_W     = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     in_kind,
  input  logic [KEY_W-1:0]               in_key,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           in_last,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [2:0]                     cmd_op,
  output logic [KEY_W-1:0]               cmd_key,
  output logic [DATA_W-1:0]              cmd_data,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic                           done,
  output logic                           err_kind,
  output logic                           err_depth
);
  state_e             r_state;
  logic               r_cmd_valid;
  op_e                r_cmd_op;
  logic [KEY_W-1:0]   r_cmd_key;
  logic [DATA_W-1:0]  r_cmd_data;
  logic [KEY_W-1:0]   r_key;
  logic               r_last;
  logic               r_done;
  logic               r_err_kind;
  logic               r_err_depth;

  logic               w_adv;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [KEY_W-1:0]   w_top;
  kind_e              w_kind;

  // The command slot is free when empty or being taken this cycle.
  assign w_adv    = !r_cmd_valid || cmd_ready;
  assign in_ready = (r_state == ST_READY) && !r_cmd_valid;
  assign w_accept = in_valid && in_ready;
  assign w_kind   = kind_e'(in_kind);
  assign w_push   = w_accept && (w_kind == K_OBJ_BEGIN) && !w_full;
  assign w_pop    = (w_accept && (w_kind == K_OBJ_END) && !w_empty) ||
                    ((r_state == ST_CLOSE) && w_adv && !w_empty);

  vmujs_key_stack #(
    .KEY_W     (KEY_W),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_key_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_key   (in_key),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (depth)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NEWOBJ;
      r_cmd_key   <= '0;
      r_cmd_data  <= '0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_err_kind  <= 1'b0;
      r_err_depth <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_valid <= 1'b1;
          r_cmd_op    <= OP_NEWOBJ;
          r_cmd_key   <= '0;
          r_cmd_data  <= '0;
          r_state     <= ST_ROOT;
        end
        ST_ROOT, ST_SET: if (cmd_ready) begin
          r_cmd_valid <= 1'b0;
          r_cmd_op    <= OP_NEWOBJ;
          r_cmd_key   <= '0;
          r_cmd_data  <= '0;
          r_state     <= (r_state == ST_SET && r_last) ? ST_CLOSE : ST_READY;
        end
        ST_READY: if (w_accept) begin
          r_key       <= in_key;
          r_last      <= in_last;
          r_cmd_valid <= 1'b1;
          r_cmd_op    <= push_op(w_kind);
          r_cmd_key   <= '0;
          r_cmd_data  <= '0;
          r_state     <= ST_PUSH;
          case (w_kind)
            K_STR, K_INT: r_cmd_data <= in_data;
            K_BOOL:       r_cmd_data <= DATA_W'(in_data[0]);
            K_RSVD:       r_err_kind <= 1'b1;
            K_OBJ_BEGIN: begin
              if (w_full) begin
                r_err_depth <= 1'b1;
              end else begin
                r_cmd_op <= OP_NEWOBJ;
                r_state  <= ST_SET;
              end
            end
            K_OBJ_END: begin
              if (!w_empty) begin
                r_cmd_op  <= OP_SETPROP;
                r_cmd_key <= w_top;
                r_state   <= ST_SET;
              end else begin
                // Unbalanced END is dropped without emitting anything.
                r_err_depth <= 1'b1;
                r_cmd_valid <= 1'b0;
                r_cmd_op    <= OP_NEWOBJ;
                r_state     <= in_last ? ST_CLOSE : ST_READY;
              end
            end
            default: ;
          endcase
        end
        ST_PUSH: if (cmd_ready) begin
          r_cmd_op   <= OP_SETPROP;
          r_cmd_key  <= r_key;
          r_cmd_data <= '0;
          r_state    <= ST_SET;
        end
        ST_CLOSE: if (w_adv) begin
          if (!w_empty) begin
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= OP_SETPROP;
            r_cmd_key   <= w_top;
            r_cmd_data  <= '0;
            r_err_depth <= 1'b1;
          end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_NEWOBJ;
            r_cmd_key   <= '0;
            r_cmd_data  <= '0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign cmd_key   = r_cmd_key;
  assign cmd_data  = r_cmd_data;
  assign done      = r_done;
  assign err_kind  = r_err_kind;
  assign err_depth = r_err_depth;

endmodule

// File: tb/tb_vmujs_object_builder.sv
// Directed bench for vmujs_object_builder: captures handshaken commands and compares streams.
module tb_vmujs_object_builder;
  import vmujs_pkg::*;

  localparam int KEY_W     = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0;
  logic [KEY_W-1:0]  in_key = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [KEY_W-1:0]  cmd_key;
  logic [DATA_W-1:0] cmd_data;
  logic [2:0]        depth;
  logic              done;
  logic              err_kind;
  logic              err_depth;

  int n_checks = 0;
  int n_err    = 0;

  logic [50:0] q[$];
  logic [50:0] eq[$];
  logic        prev_stall = 1'b0;
  logic [51:0] prev_cmd = '0;
  logic        rand_mode = 1'b0;
  logic        ready_force = 1'b1;
  logic        r_rand = 1'b1;

  always #5 clk = ~clk;

  assign cmd_ready = rand_mode ? r_rand : ready_force;

  always @(posedge clk) begin
    #1;
    r_rand = ($urandom_range(0, 99) < 30);
  end

  vmujs_object_builder #(
    .KEY_W(KEY_W), .DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_key(in_key), .in_data(in_data), .in_last(in_last),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_data(cmd_data),
    .depth(depth), .done(done), .err_kind(err_kind), .err_depth(err_depth)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [50:0] c(input logic [2:0] op, input logic [15:0] k, input logic [31:0] d);
    return {op, k, d};
  endfunction

  // Command monitor: records accepted commands and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {12'd0, cmd_valid, cmd_op, cmd_key, cmd_data}, {12'd0, prev_cmd});
      if (cmd_valid && cmd_ready) q.push_back({cmd_op, cmd_key, cmd_data});
      prev_stall = cmd_valid && !cmd_ready;
      prev_cmd   = {cmd_valid, cmd_op, cmd_key, cmd_data};
    end
  end

  task automatic send(input logic [2:0] k, input logic [15:0] key, input logic [31:0] d, input logic last);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_kind = k; in_key = key; in_data = d; in_last = last;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    chk("send_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 1000);
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 64'(q.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), (i < q.size()) ? {13'd0, q[i]} : 64'hx, {13'd0, eq[i]});
    q.delete();
    eq.delete();
  endtask

  task automatic exp_stream2();
    eq.push_back(c(OP_NEWOBJ, 0, 0));
    eq.push_back(c(OP_NEWOBJ, 0, 0));
    eq.push_back(c(OP_PUSH_BOOL, 0, 1));
    eq.push_back(c(OP_SETPROP, 2, 0));
    eq.push_back(c(OP_SETPROP, 1, 0));
    eq.push_back(c(OP_PUSH_STR, 0, 7));
    eq.push_back(c(OP_SETPROP, 4, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {5'd0, cmd_valid, cmd_op, cmd_key, cmd_data, depth, done, err_kind, err_depth, in_ready}, 64'd0);
    rst = 1'b0;

    // Single scalar entry closing the root object
    send(K_INT, 16'd3, 32'd42, 1'b1);
    wait_done("t1_done");
    eq.push_back(c(OP_NEWOBJ, 0, 0));
    eq.push_back(c(OP_PUSH_INT, 0, 42));
    eq.push_back(c(OP_SETPROP, 3, 0));
    check_stream("t1");
    chk("t1_depth", 64'(depth), 64'd0);
    @(negedge clk);
    chk("t1_done_pulse", {63'd0, done}, 64'd0);

    // One nested object; BOOL payload reduced to bit 0
    send(K_OBJ_BEGIN, 16'd1, 32'd0, 1'b0);
    chk("t2_depth1", 64'(depth), 64'd1);
    send(K_BOOL, 16'd2, 32'hFFFF_FFFF, 1'b0);
    send(K_OBJ_END, 16'd0, 32'd0, 1'b0);
    chk("t2_depth0", 64'(depth), 64'd0);
    send(K_STR, 16'd4, 32'd7, 1'b1);
    wait_done("t2_done");
    exp_stream2();
    check_stream("t2");

    // Nesting overflow and auto-close of open levels
    for (int i = 0; i < MAX_DEPTH; i++) send(K_OBJ_BEGIN, 16'(10 + i), 32'd0, 1'b0);
    chk("t3_depth_full", 64'(depth), 64'd4);
    chk("t3_err_before", {62'd0, err_kind, err_depth}, 64'd0);
    send(K_OBJ_BEGIN, 16'd14, 32'd0, 1'b0);
    chk("t3_err_overflow", {63'd0, err_depth}, 64'd1);
    chk("t3_depth_hold", 64'(depth), 64'd4);
    send(K_INT, 16'd20, 32'd5, 1'b1);
    wait_done("t3_done");
    eq.push_back(c(OP_NEWOBJ, 0, 0));
    for (int i = 0; i < MAX_DEPTH; i++) eq.push_back(c(OP_NEWOBJ, 0, 0));
    eq.push_back(c(OP_PUSH_UNDEF, 0, 0));
    eq.push_back(c(OP_SETPROP, 14, 0));
    eq.push_back(c(OP_PUSH_INT, 0, 5));
    eq.push_back(c(OP_SETPROP, 20, 0));
    eq.push_back(c(OP_SETPROP, 13, 0));
    eq.push_back(c(OP_SETPROP, 12, 0));
    eq.push_back(c(OP_SETPROP, 11, 0));
    eq.push_back(c(OP_SETPROP, 10, 0));
    check_stream("t3");
    chk("t3_depth_end", 64'(depth), 64'd0);

    // Reserved kind and unbalanced END, from a clean reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_err_cleared", {62'd0, err_kind, err_depth}, 64'd0);
    rst = 1'b0;
    q.delete();
    send(3'd7, 16'd9, 32'd123, 1'b0);
    chk("t4_err_kind", {62'd0, err_kind, err_depth}, 64'd2);
    send(K_OBJ_END, 16'd0, 32'd0, 1'b0);
    chk("t4_err_depth", {62'd0, err_kind, err_depth}, 64'd3);
    send(K_NULL, 16'd5, 32'd55, 1'b1);
    wait_done("t4_done");
    eq.push_back(c(OP_NEWOBJ, 0, 0));
    eq.push_back(c(OP_PUSH_UNDEF, 0, 0));
    eq.push_back(c(OP_SETPROP, 9, 0));
    eq.push_back(c(OP_PUSH_NULL, 0, 0));
    eq.push_back(c(OP_SETPROP, 5, 0));
    check_stream("t4");

    // Backpressure: same stream as the nested case, engine ready 30% of cycles
    rand_mode = 1'b1;
    send(K_OBJ_BEGIN, 16'd1, 32'd0, 1'b0);
    send(K_BOOL, 16'd2, 32'hFFFF_FFFF, 1'b0);
    send(K_OBJ_END, 16'd0, 32'd0, 1'b0);
    send(K_STR, 16'd4, 32'd7, 1'b1);
    wait_done("t5_done");
    exp_stream2();
    check_stream("t5");
    rand_mode = 1'b0;
    ready_force = 1'b1;

    // Reset while a PUSH command is stalled
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 100);
    chk("t6_ready", {63'd0, in_ready}, 64'd1);
    ready_force = 1'b0;
    send(K_INT, 16'd6, 32'd99, 1'b0);
    chk("t6_push_pending", {60'd0, cmd_valid, cmd_op}, {60'd0, 1'b1, OP_PUSH_INT});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_reset_outs", {5'd0, cmd_valid, cmd_op, cmd_key, cmd_data, depth, done, err_kind, err_depth, in_ready}, 64'd0);
    rst = 1'b0;
    ready_force = 1'b1;
    q.delete();
    send(K_INT, 16'd3, 32'd42, 1'b1);
    wait_done("t6_done");
    eq.push_back(c(OP_NEWOBJ, 0, 0));
    eq.push_back(c(OP_PUSH_INT, 0, 42));
    eq.push_back(c(OP_SETPROP, 3, 0));
    check_stream("t6");
    chk("t6_err_clear", {62'd0, err_kind, err_depth}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
